// File: rtl/ghost_collision_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ghost_collision_ctrl
// Brief    : Life/round controller; freezes movers on a catch, pulses ghost_rst
//            on respawn, tracks lives and game over. Optional proximity hit
//            detection is enabled by defining PROXIMITY_HIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ghost_collision_ctrl #(
    parameter int NUM_GHOSTS     = 4,
    parameter int LIVES_INIT     = 3,
    parameter int FREEZE_FRAMES  = 120,
    parameter int RESPAWN_FRAMES = 60,
    parameter int HIT_RADIUS     = 5
) (
    input  logic                     Reset,
    input  logic                     frame_clk,
    input  logic                     start,
    input  logic [NUM_GHOSTS-1:0]    ghost_collide,
    input  logic [10*NUM_GHOSTS-1:0] ghost_x,
    input  logic [10*NUM_GHOSTS-1:0] ghost_y,
    input  logic [9:0]               pac_x,
    input  logic [9:0]               pac_y,
    output logic                     stop,
    output logic                     ghost_rst,
    output logic [2:0]               lives,
    output logic                     game_over,
    output logic [1:0]               hit_id
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PLAY    = 3'd1;
    localparam logic [2:0] S_CAUGHT  = 3'd2;
    localparam logic [2:0] S_RESPAWN = 3'd3;
    localparam logic [2:0] S_OVER    = 3'd4;

    localparam logic [7:0] c_freeze_load  = 8'(FREEZE_FRAMES - 1);
    localparam logic [7:0] c_respawn_load = 8'(RESPAWN_FRAMES - 1);
    localparam logic [2:0] c_lives_init   = 3'(LIVES_INIT);

    logic [2:0] r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_stop, w_stop_nxt;
    logic       r_ghost_rst, w_ghost_rst_nxt;
    logic [2:0] r_lives, w_lives_nxt;
    logic       r_game_over, w_game_over_nxt;
    logic [1:0] r_hit_id, w_hit_id_nxt;

    logic [3:0] w_hit;
    logic       w_any_hit;
    logic [1:0] w_first_hit;

    // Per-ghost hit terms; slots beyond NUM_GHOSTS never hit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ghost
            if (gi < NUM_GHOSTS) begin : g_used
`ifdef PROXIMITY_HIT_EN
                logic [9:0] w_gx, w_gy, w_dx, w_dy;
                assign w_gx = ghost_x[10*gi +: 10];
                assign w_gy = ghost_y[10*gi +: 10];
                // Larger minus smaller keeps the distance from wrapping near 0.
                assign w_dx = (w_gx > pac_x) ? (w_gx - pac_x) : (pac_x - w_gx);
                assign w_dy = (w_gy > pac_y) ? (w_gy - pac_y) : (pac_y - w_gy);
                assign w_hit[gi] = ghost_collide[gi] |
                                   ((w_dx <= 10'(HIT_RADIUS)) && (w_dy <= 10'(HIT_RADIUS)));
`else
                assign w_hit[gi] = ghost_collide[gi];
`endif
            end else begin : g_tied
                assign w_hit[gi] = 1'b0;
            end
        end
    endgenerate

`ifndef PROXIMITY_HIT_EN
    logic w_unused_pos;
    assign w_unused_pos = ^{ghost_x, ghost_y, pac_x, pac_y};
`endif

    assign w_any_hit = |w_hit;

    always_comb begin
        w_first_hit = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_hit[i]) w_first_hit = 2'(i);
        end
    end

    // State and output registers
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_stop      <= 1'b1;
            r_ghost_rst <= 1'b0;
            r_lives     <= 3'd0;
            r_game_over <= 1'b0;
            r_hit_id    <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_stop      <= w_stop_nxt;
            r_ghost_rst <= w_ghost_rst_nxt;
            r_lives     <= w_lives_nxt;
            r_game_over <= w_game_over_nxt;
            r_hit_id    <= w_hit_id_nxt;
        end
    end

    // Next state and frame counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    w_state_nxt = S_RESPAWN;
                    w_cnt_nxt   = c_respawn_load;
                end
            end
            S_PLAY: begin
                if (w_any_hit) begin
                    w_state_nxt = S_CAUGHT;
                    w_cnt_nxt   = c_freeze_load;
                end
            end
            S_CAUGHT: begin
                if (r_cnt == 8'd0) begin
                    if (r_lives == 3'd0) begin
                        w_state_nxt = S_OVER;
                    end else begin
                        w_state_nxt = S_RESPAWN;
                        w_cnt_nxt   = c_respawn_load;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_RESPAWN: begin
                if (r_cnt == 8'd0) w_state_nxt = S_PLAY;
                else               w_cnt_nxt   = r_cnt - 8'd1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Next output values, registered alongside the state
    always_comb begin
        w_stop_nxt      = (w_state_nxt != S_PLAY);
        w_ghost_rst_nxt = (w_state_nxt == S_RESPAWN) && (r_state != S_RESPAWN);
        w_game_over_nxt = (w_state_nxt == S_OVER);
        w_lives_nxt     = r_lives;
        w_hit_id_nxt    = r_hit_id;
        if (((r_state == S_IDLE) || (r_state == S_OVER)) && start) begin
            w_lives_nxt = c_lives_init;
        end else if ((r_state == S_PLAY) && w_any_hit) begin
            w_lives_nxt  = (r_lives == 3'd0) ? 3'd0 : (r_lives - 3'd1);
            w_hit_id_nxt = w_first_hit;
        end
    end

    assign stop      = r_stop;
    assign ghost_rst = r_ghost_rst;
    assign lives     = r_lives;
    assign game_over = r_game_over;
    assign hit_id    = r_hit_id;

endmodule
`default_nettype wire

// File: tb/tb_ghost_collision_ctrl.sv
`default_nettype none
// Directed bench for ghost_collision_ctrl with default parameters
// (3 lives, 120 freeze frames, 60 respawn frames).
module tb_ghost_collision_ctrl;

    logic        Reset;
    logic        frame_clk;
    logic        start;
    logic [3:0]  ghost_collide;
    logic [39:0] ghost_x;
    logic [39:0] ghost_y;
    logic [9:0]  pac_x;
    logic [9:0]  pac_y;
    logic        stop;
    logic        ghost_rst;
    logic [2:0]  lives;
    logic        game_over;
    logic [1:0]  hit_id;

    int total = 0;
    int bad   = 0;

    ghost_collision_ctrl dut (
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .start        (start),
        .ghost_collide(ghost_collide),
        .ghost_x      (ghost_x),
        .ghost_y      (ghost_y),
        .pac_x        (pac_x),
        .pac_y        (pac_y),
        .stop         (stop),
        .ghost_rst    (ghost_rst),
        .lives        (lives),
        .game_over    (game_over),
        .hit_id       (hit_id)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic wait_rst(output int n);
        n = 0;
        do begin tick(); n++; end while (!ghost_rst && n < 400);
    endtask

    task automatic wait_play(output int n, output int pulses);
        n = 0; pulses = 0;
        do begin tick(); n++; if (ghost_rst) pulses++; end while (stop && n < 400);
    endtask

    task automatic wait_over(output int n);
        n = 0;
        do begin tick(); n++; end while (!game_over && n < 400);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(); tick();
        total++; if (stop !== 1'b1) begin bad++; $display("FAIL reset_stop got=%0b want=1", stop); end
        total++; if (ghost_rst !== 1'b0) begin bad++; $display("FAIL reset_ghost_rst got=%0b want=0", ghost_rst); end
        total++; if (lives !== 3'd0) begin bad++; $display("FAIL reset_lives got=%0d want=0", lives); end
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL reset_game_over got=%0b want=0", game_over); end
        total++; if (hit_id !== 2'd0) begin bad++; $display("FAIL reset_hit_id got=%0d want=0", hit_id); end
        Reset = 1'b0;
        tick(); tick();
        total++; if (stop !== 1'b1) begin bad++; $display("FAIL idle_stop got=%0b want=1", stop); end
    endtask

    task automatic test_start();
        int n, p;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (ghost_rst !== 1'b1) begin bad++; $display("FAIL start_ghost_rst got=%0b want=1", ghost_rst); end
        total++; if (lives !== 3'd3) begin bad++; $display("FAIL start_lives got=%0d want=3", lives); end
        total++; if (stop !== 1'b1) begin bad++; $display("FAIL start_stop got=%0b want=1", stop); end
        wait_play(n, p);
        total++; if (n !== 60) begin bad++; $display("FAIL start_respawn_len got=%0d want=60", n); end
        total++; if (p !== 0) begin bad++; $display("FAIL start_extra_rst got=%0d want=0", p); end
    endtask

    task automatic test_single_hit();
        int n, p;
        ghost_collide = 4'b0100;
        tick();
        total++; if (stop !== 1'b1) begin bad++; $display("FAIL hit1_stop got=%0b want=1", stop); end
        total++; if (lives !== 3'd2) begin bad++; $display("FAIL hit1_lives got=%0d want=2", lives); end
        total++; if (hit_id !== 2'd2) begin bad++; $display("FAIL hit1_hit_id got=%0d want=2", hit_id); end
        wait_rst(n);
        ghost_collide = 4'b0000;
        total++; if (n !== 120) begin bad++; $display("FAIL hit1_caught_len got=%0d want=120", n); end
        wait_play(n, p);
        total++; if (n !== 60) begin bad++; $display("FAIL hit1_respawn_len got=%0d want=60", n); end
        total++; if (lives !== 3'd2) begin bad++; $display("FAIL hit1_lives_held got=%0d want=2", lives); end
    endtask

    task automatic test_multi_hit();
        int n, p;
        ghost_collide = 4'b1011;
        tick();
        total++; if (lives !== 3'd1) begin bad++; $display("FAIL multi_lives got=%0d want=1", lives); end
        total++; if (hit_id !== 2'd0) begin bad++; $display("FAIL multi_hit_id got=%0d want=0", hit_id); end
        wait_rst(n);
        ghost_collide = 4'b0000;
        total++; if (n !== 120) begin bad++; $display("FAIL multi_caught_len got=%0d want=120", n); end
        wait_play(n, p);
        total++; if (lives !== 3'd1) begin bad++; $display("FAIL multi_lives_held got=%0d want=1", lives); end
    endtask

    task automatic test_game_over();
        int n, p;
        ghost_collide = 4'b0010;
        tick();
        total++; if (lives !== 3'd0) begin bad++; $display("FAIL over_lives0 got=%0d want=0", lives); end
        total++; if (hit_id !== 2'd1) begin bad++; $display("FAIL over_hit_id got=%0d want=1", hit_id); end
        wait_over(n);
        ghost_collide = 4'b0000;
        total++; if (n !== 120) begin bad++; $display("FAIL over_caught_len got=%0d want=120", n); end
        total++; if (stop !== 1'b1) begin bad++; $display("FAIL over_stop got=%0b want=1", stop); end
        total++; if (ghost_rst !== 1'b0) begin bad++; $display("FAIL over_ghost_rst got=%0b want=0", ghost_rst); end
        tick(); tick(); tick();
        total++; if (game_over !== 1'b1) begin bad++; $display("FAIL over_hold got=%0b want=1", game_over); end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (lives !== 3'd3) begin bad++; $display("FAIL restart_lives got=%0d want=3", lives); end
        total++; if (ghost_rst !== 1'b1) begin bad++; $display("FAIL restart_ghost_rst got=%0b want=1", ghost_rst); end
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL restart_game_over got=%0b want=0", game_over); end
        wait_play(n, p);
        total++; if (n !== 60) begin bad++; $display("FAIL restart_respawn_len got=%0d want=60", n); end
    endtask

    task automatic test_reset_mid();
        int n, p;
        ghost_collide = 4'b0001;
        repeat (11) tick();
        Reset = 1'b1;
        #1;
        total++; if (stop !== 1'b1) begin bad++; $display("FAIL async_stop got=%0b want=1", stop); end
        total++; if (lives !== 3'd0) begin bad++; $display("FAIL async_lives got=%0d want=0", lives); end
        total++; if (ghost_rst !== 1'b0) begin bad++; $display("FAIL async_ghost_rst got=%0b want=0", ghost_rst); end
        ghost_collide = 4'b0000;
        #2 Reset = 1'b0;
        repeat (5) tick();
        total++; if (stop !== 1'b1 || lives !== 3'd0) begin bad++; $display("FAIL idle_wait got stop=%0b lives=%0d want stop=1 lives=0", stop, lives); end
        start = 1'b1;
        tick();
        start = 1'b0;
        Reset = 1'b1;
        #1;
        total++; if (ghost_rst !== 1'b0) begin bad++; $display("FAIL drop_pulse got=%0b want=0", ghost_rst); end
        #2 Reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_play(n, p);
        total++; if (n !== 60) begin bad++; $display("FAIL reset_respawn_len got=%0d want=60", n); end
        total++; if (lives !== 3'd3) begin bad++; $display("FAIL reset_resume_lives got=%0d want=3", lives); end
    endtask

`ifdef PROXIMITY_HIT_EN
    task automatic test_proximity();
        int n, p;
        ghost_x[9:0] = 10'd100; ghost_y[9:0] = 10'd200;
        pac_x = 10'd104; pac_y = 10'd197;
        tick();
        pac_x = 10'd600; pac_y = 10'd600;
        total++; if (lives !== 3'd2) begin bad++; $display("FAIL prox_near_lives got=%0d want=2", lives); end
        wait_rst(n);
        wait_play(n, p);
        pac_x = 10'd106; pac_y = 10'd200;
        repeat (3) tick();
        total++; if (stop !== 1'b0 || lives !== 3'd2) begin bad++; $display("FAIL prox_far got stop=%0b lives=%0d want stop=0 lives=2", stop, lives); end
        ghost_x[9:0] = 10'd3; pac_x = 10'd0;
        tick();
        pac_x = 10'd600;
        total++; if (lives !== 3'd1) begin bad++; $display("FAIL prox_edge_lives got=%0d want=1", lives); end
    endtask
`endif

    initial begin
        Reset = 1'b1;
        start = 1'b0;
        ghost_collide = 4'b0000;
        ghost_x = {4{10'd500}};
        ghost_y = {4{10'd500}};
        pac_x = 10'd0;
        pac_y = 10'd0;
        test_reset();
        test_start();
        test_single_hit();
        test_multi_hit();
        test_game_over();
        test_reset_mid();
`ifdef PROXIMITY_HIT_EN
        test_proximity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
